data_memory_responder: RTL and testbench
========================================

Name: data_memory_responder

Overview:
Responder end of the core's data-memory interface. It answers the CPU's data_memory_* address, read and write signals with single-cycle semantics. Reads are combinational and same-cycle. Writes commit on the clock edge. It holds a word RAM plus a small MMIO page containing a console TX FIFO (valid/ready drain), a status/sticky-error register and a free-running cycle counter. It sits beside the CPU in the testbench top, replacing the flat memory model.

Parameters:
RAM_WORDS, 1024, number of 32-bit RAM words; RAM occupies byte addresses 0 .. RAM_WORDS*4-1
FIFO_DEPTH, 8, console FIFO entries; power of two, 2..16
MMIO_BASE, 32'hFFFF0000, byte base address of the MMIO page
UNMAPPED_VALUE, 32'h00000000, read data returned for unmapped addresses

Ports:
clk  input  1  core clock
nreset  input  1  asynchronous active-low reset
clk_en  input  1  clock enable; gates RAM/MMIO writes and the cycle counter
data_memory_a  input  32  byte address from CPU
data_memory_out_v  input  32  write data from CPU
data_memory_read  input  1  read strobe; informational, reads have no side effects
data_memory_write  input  1  write strobe
data_memory_in_v  output  32  read data to CPU
console_data  output  8  FIFO head byte
console_valid  output  1  FIFO non-empty
console_ready  input  1  consumer accepts head byte
access_error  output  1  sticky error flag

Behaviour:
- Address decode uses word index a[31:2]. a[1:0] is ignored for reads.
- RAM hit: a < RAM_WORDS*4. MMIO hit: a[31:4] == MMIO_BASE[31:4]. Anything else is unmapped.
- Read path is purely combinational from data_memory_a, with zero latency and no state change:
  - RAM returns the stored word.
  - MMIO offset 0x0 reads 0.
  - MMIO offset 0x4 returns status: bit0 empty, bit1 full, bits[8:4] count (zero-extended), bit9 overflow sticky, bit10 access_error sticky.
  - MMIO offset 0x8 returns the cycle counter.
  - MMIO offset 0xC and unmapped addresses return UNMAPPED_VALUE.
- Writes are accepted at posedge clk when data_memory_write & clk_en:
  - RAM: word a[31:2] is written with data_memory_out_v.
  - 0x0: push data_memory_out_v[7:0] into the FIFO. If the FIFO is full and no pop occurs that cycle, the byte is dropped and overflow is set.
  - 0x4: write-1-to-clear. Bit9 clears overflow; bit10 clears access_error. Other bits are ignored.
  - 0x8: load the counter with the write data. The load wins over the increment that cycle.
  - Unmapped address, MMIO 0xC, or a[1:0] != 0 on any write: the write is discarded and access_error is set.
  - A set and a clear of the same sticky in one cycle: the set wins.
- Cycle counter: 32-bit, increments by 1 every clk with clk_en=1 and wraps at 0xFFFFFFFF to 0.
- Console FIFO:
  - Pop occurs when console_valid & console_ready at posedge clk. Pop is not gated by clk_en, so draining continues while the CPU is stalled.
  - console_valid = (count != 0). console_data = head entry and is stable while valid & ~ready.
  - Simultaneous push and pop: both take effect and count is unchanged. This holds even when full.
  - Push into empty: valid rises the next cycle; data is not bypassed.
  - Pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.
- Reset (nreset low, asynchronous):
  - FIFO is flushed: count=0, pointers=0, console_valid=0 immediately.
  - console_data=0, counter=0, overflow=0, access_error=0.
  - RAM contents are not reset.
  - data_memory_in_v stays combinational, so RAM reads still return contents and MMIO reads reflect the reset state.
  - Reset during a pending write aborts that write.
- clk_en low: no RAM/MMIO write, counter holds, FIFO pop still permitted.

Test Plan:
1. Reset, then write 0x12345678 to 0x00000010 with clk_en=1, then read 0x10 and 0x13 -> data_memory_in_v=0x12345678 same cycle for both. Read 0x14 -> 0 after an earlier write of 0 to 0x14.
2. console_ready=0; write 0x41..0x49 to MMIO_BASE+0 (9 pushes) -> after 8 pushes status=0x00000082 (full, count 8). The 9th is dropped and status bit9 is set. console_data=0x41 with valid=1.
3. Full FIFO; in the same cycle push 0x50 and assert console_ready -> count stays 8, head becomes 0x42. Then drain with ready=1 -> bytes 0x42..0x48,0x50 in order, and valid drops after the last.
4. Write to 0x00100000 (unmapped) and to 0x00000006 (misaligned) -> access_error=1 and RAM is unchanged. Write 0x400 to MMIO_BASE+4 -> access_error=0. Write plus clear in the same cycle -> stays 1.
5. Load counter with 0xFFFFFFFE, hold clk_en high for 3 cycles -> read values 0xFFFFFFFF, 0x00000000, 0x00000001. clk_en low for 5 cycles -> value holds and a RAM write during that window has no effect.
6. FIFO holds 3 bytes, counter=0x55. Assert nreset low between edges -> console_valid=0 immediately, status read=0x00000001, counter=0, and RAM data written before reset is still readable.

Source files
------------

// File: rtl/data_memory_responder.sv
// Data-memory responder: word RAM plus an MMIO page holding a console TX FIFO,
// a status/sticky-error register and a free-running cycle counter.
module data_memory_responder #(
  parameter int          RAM_WORDS      = 1024,
  parameter int          FIFO_DEPTH     = 8,
  parameter logic [31:0] MMIO_BASE      = 32'hFFFF0000,
  parameter logic [31:0] UNMAPPED_VALUE = 32'h00000000
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        clk_en,
  input  logic [31:0] data_memory_a,
  input  logic [31:0] data_memory_out_v,
  input  logic        data_memory_read,
  input  logic        data_memory_write,
  output logic [31:0] data_memory_in_v,
  output logic [7:0]  console_data,
  output logic        console_valid,
  input  logic        console_ready,
  output logic        access_error
);

  localparam int              RAM_AW     = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int              PTR_W      = $clog2(FIFO_DEPTH);
  localparam int              CNT_W      = PTR_W + 1;
  localparam logic [31:0]     RAM_BYTES  = 32'(RAM_WORDS * 4);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [1:0]      OFF_TX     = 2'd0;
  localparam logic [1:0]      OFF_STATUS = 2'd1;
  localparam logic [1:0]      OFF_CYCLE  = 2'd2;
  localparam logic [1:0]      OFF_RSVD   = 2'd3;

  logic [31:0]      ram_q [RAM_WORDS];
  logic [7:0]       fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      cycle_q, cycle_d;
  logic             overflow_q, overflow_d;
  logic             err_q, err_d;

  logic              ram_hit, mmio_hit, aligned, wr_en;
  logic [1:0]        offset;
  logic [RAM_AW-1:0] ram_idx;
  logic              ram_we, push_req, clear_req, load_req, bad_wr;
  logic              fifo_empty, fifo_full, push, pop;
  logic [31:0]       status;

  // Reads carry no side effects, so the read strobe is only informational.
  logic unused_read;
  assign unused_read = data_memory_read;

  assign ram_hit  = data_memory_a < RAM_BYTES;
  assign mmio_hit = data_memory_a[31:4] == MMIO_BASE[31:4];
  assign offset   = data_memory_a[3:2];
  assign ram_idx  = data_memory_a[RAM_AW+1:2];
  assign aligned  = data_memory_a[1:0] == 2'b00;
  assign wr_en    = data_memory_write & clk_en;

  assign ram_we    = wr_en & aligned & ram_hit;
  assign push_req  = wr_en & aligned & ~ram_hit & mmio_hit & (offset == OFF_TX);
  assign clear_req = wr_en & aligned & ~ram_hit & mmio_hit & (offset == OFF_STATUS);
  assign load_req  = wr_en & aligned & ~ram_hit & mmio_hit & (offset == OFF_CYCLE);
  assign bad_wr    = wr_en & (~aligned | ~(ram_hit | mmio_hit) |
                              (~ram_hit & mmio_hit & (offset == OFF_RSVD)));

  // console_valid/console_ready: a byte transfers on every posedge where both
  // are high (independent of clk_en); head data holds while valid & ~ready.
  assign fifo_empty = count_q == '0;
  assign fifo_full  = count_q == FULL_CNT;
  assign pop        = ~fifo_empty & console_ready;
  assign push       = push_req & (~fifo_full | pop);

  assign console_valid = ~fifo_empty;
  assign console_data  = fifo_empty ? 8'h00 : fifo_q[rd_ptr_q];
  assign access_error  = err_q;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // A same-cycle set beats a clear of the same sticky bit.
    overflow_d = (overflow_q & ~(clear_req & data_memory_out_v[9])) |
                 (push_req & fifo_full & ~pop);
    err_d      = (err_q & ~(clear_req & data_memory_out_v[10])) | bad_wr;
    if (load_req)    cycle_d = data_memory_out_v;
    else if (clk_en) cycle_d = cycle_q + 32'd1;
    else             cycle_d = cycle_q;
  end

  always_comb begin
    status = {21'b0, err_q, overflow_q, 5'(count_q), 2'b00, fifo_full, fifo_empty};
    data_memory_in_v = UNMAPPED_VALUE;
    if (ram_hit) begin
      data_memory_in_v = ram_q[ram_idx];
    end else if (mmio_hit) begin
      case (offset)
        OFF_TX:     data_memory_in_v = 32'h0;
        OFF_STATUS: data_memory_in_v = status;
        OFF_CYCLE:  data_memory_in_v = cycle_q;
        default:    data_memory_in_v = UNMAPPED_VALUE;
      endcase
    end
  end

  // Storage arrays are not reset; an edge that lands inside reset is ignored.
  always_ff @(posedge clk) begin
    if (nreset && ram_we) ram_q[ram_idx] <= data_memory_out_v;
    if (nreset && push)   fifo_q[wr_ptr_q] <= data_memory_out_v[7:0];
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cycle_q    <= 32'h0;
      overflow_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      cycle_q    <= cycle_d;
      overflow_q <= overflow_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: queue/array model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_data_memory_responder;

  localparam logic [31:0] MMIO = 32'hFFFF0000;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        clk_en = 1'b1;
  logic [31:0] data_memory_a = 32'h0;
  logic [31:0] data_memory_out_v = 32'h0;
  logic        data_memory_read = 1'b0;
  logic        data_memory_write = 1'b0;
  logic [31:0] data_memory_in_v;
  logic [7:0]  console_data;
  logic        console_valid;
  logic        console_ready = 1'b0;
  logic        access_error;

  int n_checks = 0;
  int n_fail   = 0;

  data_memory_responder dut (
    .clk               (clk),
    .nreset            (nreset),
    .clk_en            (clk_en),
    .data_memory_a     (data_memory_a),
    .data_memory_out_v (data_memory_out_v),
    .data_memory_read  (data_memory_read),
    .data_memory_write (data_memory_write),
    .data_memory_in_v  (data_memory_in_v),
    .console_data      (console_data),
    .console_valid     (console_valid),
    .console_ready     (console_ready),
    .access_error      (access_error)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Behavioural model
  logic [31:0] m_ram [logic [29:0]];
  logic [7:0]  m_fifo [$];
  logic [31:0] m_cycle = 32'h0;
  bit          m_ovf = 1'b0;
  bit          m_err = 1'b0;
  logic [31:0] m_a, m_d;
  bit          m_wr, m_in_ram, m_in_mmio, m_al, m_load;

  function automatic logic [31:0] model_status();
    int n;
    n = m_fifo.size();
    return 32'(n == 0) | (32'(n == 8) << 1) | (32'(n) << 4) |
           (32'(m_ovf) << 9) | (32'(m_err) << 10);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, output bit known);
    known = 1'b1;
    if (a < 32'd4096) begin
      if (m_ram.exists(a[31:2])) return m_ram[a[31:2]];
      known = 1'b0;
      return 32'h0;
    end
    if (a[31:4] == MMIO[31:4]) begin
      case (a[3:2])
        2'd1:    return model_status();
        2'd2:    return m_cycle;
        default: return 32'h0;
      endcase
    end
    return 32'h0;
  endfunction

  always @(negedge nreset) begin
    m_fifo.delete();
    m_cycle = 32'h0;
    m_ovf   = 1'b0;
    m_err   = 1'b0;
  end

  always @(posedge clk) begin
    if (nreset) begin
      m_a       = data_memory_a;
      m_d       = data_memory_out_v;
      m_wr      = data_memory_write && clk_en;
      m_in_ram  = m_a < 32'd4096;
      m_in_mmio = m_a[31:4] == MMIO[31:4];
      m_al      = m_a[1:0] == 2'b00;
      m_load    = 1'b0;
      if (m_fifo.size() > 0 && console_ready) void'(m_fifo.pop_front());
      if (m_wr) begin
        if (!m_al || !(m_in_ram || m_in_mmio) || (!m_in_ram && m_a[3:2] == 2'd3)) begin
          m_err = 1'b1;
        end else if (m_in_ram) begin
          m_ram[m_a[31:2]] = m_d;
        end else begin
          case (m_a[3:2])
            2'd0: if (m_fifo.size() < 8) m_fifo.push_back(m_d[7:0]); else m_ovf = 1'b1;
            2'd1: begin
              if (m_d[9])  m_ovf = 1'b0;
              if (m_d[10]) m_err = 1'b0;
            end
            default: m_load = 1'b1;
          endcase
        end
      end
      if (m_load)      m_cycle = m_d;
      else if (clk_en) m_cycle = m_cycle + 32'd1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard compare: every cycle, 1 time unit after the active edge
  always @(posedge clk) begin
    bit          known;
    logic [31:0] exp_rd;
    #1;
    exp_rd = model_read(data_memory_a, known);
    if (known) check("model_rdata", data_memory_in_v, exp_rd);
    check("model_valid", 32'(console_valid), 32'(m_fifo.size() != 0));
    check("model_cdata", 32'(console_data), (m_fifo.size() != 0) ? 32'(m_fifo[0]) : 32'h0);
    check("model_err", 32'(access_error), 32'(m_err));
  end

  // Driver tasks: inputs change 2 units after the edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    data_memory_a     = a;
    data_memory_out_v = d;
    data_memory_write = 1'b1;
    data_memory_read  = 1'b0;
    tick();
    data_memory_write = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    data_memory_a    = a;
    data_memory_read = 1'b1;
    #1;
    check(name, data_memory_in_v, exp);
    data_memory_read = 1'b0;
  endtask

  logic [7:0] drain_exp [8] = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h50};

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #2;
    rd_check("rst_status", MMIO + 32'h4, 32'h00000001);
    rd_check("rst_cycle", MMIO + 32'h8, 32'h0);
    check("rst_valid", 32'(console_valid), 32'h0);
    check("rst_err", 32'(access_error), 32'h0);
    nreset = 1'b1;
    tick();

    // 1: RAM write/read, byte offset ignored on reads
    wr(32'h10, 32'h12345678);
    wr(32'h14, 32'h0);
    rd_check("ram_10", 32'h10, 32'h12345678);
    rd_check("ram_13", 32'h13, 32'h12345678);
    rd_check("ram_14", 32'h14, 32'h0);

    // 2: fill FIFO, then overflow
    console_ready = 1'b0;
    for (int i = 0; i < 8; i++) wr(MMIO, 32'h41 + 32'(i));
    rd_check("full_status", MMIO + 32'h4, 32'h00000082);
    wr(MMIO, 32'h49);
    rd_check("ovf_status", MMIO + 32'h4, 32'h00000282);
    check("head_41", 32'(console_data), 32'h41);
    check("valid_full", 32'(console_valid), 32'h1);

    // 3: push and pop together while full, then drain
    data_memory_a     = MMIO;
    data_memory_out_v = 32'h50;
    data_memory_write = 1'b1;
    console_ready     = 1'b1;
    tick();
    data_memory_write = 1'b0;
    console_ready     = 1'b0;
    rd_check("pushpop_status", MMIO + 32'h4, 32'h00000282);
    check("head_42", 32'(console_data), 32'h42);
    console_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("drain_data", 32'(console_data), 32'(drain_exp[i]));
      check("drain_valid", 32'(console_valid), 32'h1);
      tick();
    end
    #1;
    check("drained_valid", 32'(console_valid), 32'h0);
    console_ready = 1'b0;
    wr(MMIO + 32'h4, 32'h200);
    rd_check("ovf_cleared", MMIO + 32'h4, 32'h00000001);

    // 4: access errors
    wr(32'h4, 32'hAAAA5555);
    wr(32'h00100000, 32'h1111);
    #1;
    check("err_unmapped", 32'(access_error), 32'h1);
    wr(32'h6, 32'hDEADBEEF);
    rd_check("ram_unchanged", 32'h4, 32'hAAAA5555);
    rd_check("err_status", MMIO + 32'h4, 32'h00000401);
    wr(MMIO + 32'h4, 32'h400);
    #1;
    check("err_cleared", 32'(access_error), 32'h0);
    wr(MMIO + 32'hC, 32'h1);
    wr(MMIO + 32'h5, 32'h400);
    #1;
    check("err_set_wins", 32'(access_error), 32'h1);
    wr(MMIO + 32'h4, 32'h400);

    // 5: counter wrap and clk_en hold
    wr(32'h20, 32'h12);
    wr(MMIO + 32'h8, 32'hFFFFFFFE);
    rd_check("cyc_load", MMIO + 32'h8, 32'hFFFFFFFE);
    tick();
    rd_check("cyc_ff", MMIO + 32'h8, 32'hFFFFFFFF);
    tick();
    rd_check("cyc_wrap", MMIO + 32'h8, 32'h00000000);
    tick();
    rd_check("cyc_1", MMIO + 32'h8, 32'h00000001);
    clk_en = 1'b0;
    wr(32'h20, 32'h99);
    repeat (4) tick();
    rd_check("cyc_hold", MMIO + 32'h8, 32'h00000001);
    rd_check("ram_gated", 32'h20, 32'h12);
    clk_en = 1'b1;
    tick();

    // 6: asynchronous reset with FIFO contents
    for (int i = 0; i < 3; i++) wr(MMIO, 32'h61 + 32'(i));
    wr(MMIO + 32'h8, 32'h55);
    rd_check("cyc_55", MMIO + 32'h8, 32'h55);
    check("pre_rst_valid", 32'(console_valid), 32'h1);
    tick();
    nreset = 1'b0;
    #1;
    check("arst_valid", 32'(console_valid), 32'h0);
    check("arst_cdata", 32'(console_data), 32'h0);
    rd_check("arst_status", MMIO + 32'h4, 32'h00000001);
    rd_check("arst_cycle", MMIO + 32'h8, 32'h0);
    rd_check("arst_ram", 32'h10, 32'h12345678);
    tick();
    nreset = 1'b1;
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
